i2s_tx_controller: RTL
======================

I2S_TX_CONTROLLER -- requirements
Module: i2s_tx_controller

Interface
REQ-001 Parameter BCLK_HALF, default 8, SHALL set the BCLK half-period in CLOCK50MHz cycles; legal range 2..255.
REQ-002 CLOCK50MHz  input  1  sole clock; all logic SHALL be rising-edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 ENABLE  input  1  run request for the serial link.
REQ-005 LEFT_IN  input  20  unsigned left sample.
REQ-006 RIGHT_IN  input  20  unsigned right sample.
REQ-007 SAMPLE_VALID  input  1  LEFT_IN/RIGHT_IN pair valid.
REQ-008 SAMPLE_READY  output  1  one-entry holding buffer empty.
REQ-009 BCLK  output  1  bit clock to codec.
REQ-010 DACLRC  output  1  channel select; low = left, high = right.
REQ-011 DACDAT  output  1  serial data, MSB first.
REQ-012 UNDERRUN  output  1  one-cycle pulse at a frame start that found the buffer empty.

Function
REQ-013 A transfer SHALL occur on a cycle with SAMPLE_VALID and SAMPLE_READY both high; the pair is stored in the buffer and SAMPLE_READY SHALL be low from the next cycle.
REQ-014 Conversion SHALL be 2's complement = unsigned value with bit 19 inverted, placed in bits 23:4 of a 24-bit word, bits 3:0 zero.
REQ-015 The FSM SHALL have states IDLE, LEFT and RIGHT.
REQ-016 In IDLE: BCLK=0, DACLRC=1, DACDAT=0, divider=0, bit counter=63; the buffer still accepts a transfer.
REQ-017 IDLE SHALL go to LEFT when ENABLE=1; the divider then counts 0..BCLK_HALF-1 and BCLK toggles on each wrap.
REQ-018 A 6-bit bit counter SHALL increment (mod 64) on every BCLK falling transition.
REQ-019 At a falling transition where the counter wraps 63->0 (frame start), DACLRC SHALL go low.
REQ-020 At frame start, if the buffer is full, the buffered pair SHALL be loaded into the left and right shift words and the buffer freed, so SAMPLE_READY is high on the next cycle.
REQ-021 Each shift word SHALL be {1'b0, sample24, 7'b0} (32 bits), giving the standard I2S one-BCLK MSB delay.
REQ-022 The left word SHALL be shifted on slots 0..31.
REQ-023 At the 31->32 falling transition, DACLRC SHALL go high and the right word SHALL be shifted on slots 32..63.
REQ-024 DACDAT SHALL change only at BCLK falling transitions, in the same cycle as BCLK falls.
REQ-025 If the buffer is empty at frame start, UNDERRUN SHALL pulse for one cycle and the frame content follows REQ-033.
REQ-026 A transfer in the same cycle as an empty-buffer frame start SHALL NOT be used for that frame; it is stored for the next frame and UNDERRUN still pulses.
REQ-027 If ENABLE falls mid-frame, the current frame SHALL complete through slot 63, then the FSM enters IDLE at the next frame start, with no UNDERRUN and no buffer load.
REQ-028 If ENABLE is high at that boundary, the FSM SHALL continue without a gap.
REQ-029 From IDLE with ENABLE=1, BCLK SHALL rise after BCLK_HALF cycles, and the first frame start SHALL occur 2*BCLK_HALF cycles after leaving IDLE.

Reset
REQ-030 Reset, at any point including mid-frame, SHALL force state IDLE, BCLK=0, DACLRC=1, DACDAT=0, UNDERRUN=0, SAMPLE_READY=1 (buffer empty) and shift words=0, with divider and bit counter per REQ-016.
REQ-031 A transfer in the cycle RESET is high SHALL be discarded.

Configuration
REQ-032 Macro I2S_UNDERRUN_HOLD_EN defined: on underrun, the previously transmitted pair (zero after reset) SHALL be re-sent.
REQ-033 Macro undefined: on underrun, both shift words SHALL be all-zero (digital silence, 24'h000000).

Verification (BCLK_HALF=2 unless stated)
REQ-034 Reset, ENABLE=1 -> BCLK first rises 2 cycles after IDLE exit; DACLRC falls at cycle 4; BCLK period 4 cycles; DACLRC period 256 cycles.
REQ-035 Load L=20'hFFFFF, R=20'h00000 before frame start -> left slots 1..24 = 24'h7FFFF0; right slots 33..56 = 24'h800000; slots 0, 25..31, 32 and 57..63 = 0; SAMPLE_READY high the cycle after frame start.
REQ-036 No transfer for a frame after sending L=R=20'h80000 -> UNDERRUN one pulse. With HOLD_EN, both channels = 24'h000000 (repeat). Without HOLD_EN, zeros. Repeat with L=20'h90000 sent previously -> HOLD_EN gives 24'h100000.
REQ-037 SAMPLE_VALID rising on the exact frame-start cycle with empty buffer -> UNDERRUN pulses; that pair appears in the following frame.
REQ-038 ENABLE dropped at slot 10 -> slots 10..63 still transmitted, then IDLE outputs (BCLK=0, DACLRC=1); RESET asserted at slot 40 -> all REQ-030 values next cycle.
REQ-039 BCLK_HALF=8 -> BCLK period 16 cycles (3.125 MHz), frame 1024 cycles.

Source files
------------

// File: rtl/i2s_tx_controller.sv
// i2s_tx_controller: 20-bit stereo I2S transmitter with a one-entry sample buffer and a BCLK divider.
// Define I2S_UNDERRUN_HOLD_EN to repeat the last pair on underrun instead of sending silence.
module i2s_tx_controller #(
  parameter int BCLK_HALF = 8
) (
  input  logic        CLOCK50MHz,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [19:0] LEFT_IN,
  input  logic [19:0] RIGHT_IN,
  input  logic        SAMPLE_VALID,
  output logic        SAMPLE_READY,
  output logic        BCLK,
  output logic        DACLRC,
  output logic        DACDAT,
  output logic        UNDERRUN
);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} stateT;
  stateT state, stateNext;
  logic [7:0] div;
  logic [5:0] bitCnt, cntNext;
  logic bufFull;
  logic [19:0] bufLeft, bufRight;
  logic [31:0] leftWord, rightWord;
  logic divWrap, fall, frameStart, goIdle, xfer;
  // Offset-binary to two's complement, then framed with the one-BCLK I2S delay slot.
  function automatic logic [31:0] toWord(input logic [19:0] s);
    return {1'b0, ~s[19], s[18:0], 4'b0, 7'b0};
  endfunction
  assign divWrap = div == 8'(BCLK_HALF - 1);
  assign fall = state != IDLE && divWrap && BCLK;
  assign frameStart = fall && bitCnt == 6'd63;
  assign goIdle = frameStart && !ENABLE;
  assign cntNext = bitCnt + 6'd1;
  assign xfer = SAMPLE_VALID && !bufFull;
  assign SAMPLE_READY = !bufFull;
  always_ff @(posedge CLOCK50MHz) state <= RESET ? IDLE : stateNext;
  always_comb begin
    stateNext = (state == IDLE || frameStart) ? (ENABLE ? LEFT : IDLE) :
                (fall && bitCnt == 6'd31) ? RIGHT : state;
  end
  always_ff @(posedge CLOCK50MHz) begin
    if (RESET) begin
      div <= '0;
      bitCnt <= '1;
      BCLK <= 1'b0;
      DACLRC <= 1'b1;
      DACDAT <= 1'b0;
      UNDERRUN <= 1'b0;
      bufFull <= 1'b0;
      bufLeft <= '0;
      bufRight <= '0;
      leftWord <= '0;
      rightWord <= '0;
    end else begin
      UNDERRUN <= 1'b0;
      if (xfer) begin
        bufFull <= 1'b1;
        bufLeft <= LEFT_IN;
        bufRight <= RIGHT_IN;
      end
      if (state == IDLE || goIdle) begin
        div <= '0;
        bitCnt <= '1;
        BCLK <= 1'b0;
        DACLRC <= 1'b1;
        DACDAT <= 1'b0;
      end else begin
        div <= divWrap ? '0 : div + 8'd1;
        if (divWrap) BCLK <= !BCLK;
        if (fall) begin
          bitCnt <= cntNext;
          DACLRC <= cntNext[5];
          DACDAT <= cntNext[5] ? rightWord[~cntNext[4:0]] : leftWord[~cntNext[4:0]];
        end
        // A same-cycle transfer lands in the buffer above and waits for the next frame.
        if (frameStart) begin
          DACDAT <= 1'b0;
          if (bufFull) begin
            leftWord <= toWord(bufLeft);
            rightWord <= toWord(bufRight);
            bufFull <= 1'b0;
          end else begin
            UNDERRUN <= 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
            leftWord <= leftWord;
            rightWord <= rightWord;
`else
            leftWord <= '0;
            rightWord <= '0;
`endif
          end
        end
      end
    end
  end
endmodule
